test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 H_ACTIVE, 64: active pixels per line; legal range 2..4095.
REQ-002 H_BLANK, 16: blank cycles after each line; legal range 2..4095.
REQ-003 V_LINES, 32: data lines per frame after the header line; legal range 1..65535.
REQ-004 V_BLANK, 64: vertical blank cycles after the last line; must be >= 2.
REQ-005 clk  in  1  single clock; all logic in this domain.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 enable_in  in  1  level; start frames or continue generating them.
REQ-008 inject_error_in  in  1  pulse; request corruption of the next frame.
REQ-009 de_out  out  1  pixel data valid.
REQ-010 de_first_offset_line_out  out  1  high only during header-line active pixels.
REQ-011 h_sync_out  out  1  one-cycle pulse at the first blank cycle after every line.
REQ-012 v_sync_out  out  1  one-cycle pulse at the first vertical-blank cycle.
REQ-013 data_out  out  24  pixel data.
REQ-014 frame_cnt_out  out  32  frames completed; wraps modulo 2^32.

Function
REQ-015 States: IDLE, HEAD, LINE, HBLANK, VBLANK; all outputs registered; no combinational input-to-output paths.
REQ-016 IDLE -> HEAD on the cycle after enable_in is sampled high; all outputs low in IDLE.
REQ-017 HEAD:
- Lasts H_ACTIVE cycles.
- de_out=1 and de_first_offset_line_out=1.
- data_out={16'h8000, pix[7:0]}; pix counts 0..H_ACTIVE-1.
REQ-018 LINE n (n=1..V_LINES):
- Lasts H_ACTIVE cycles.
- de_out=1 and de_first_offset_line_out=0.
- data_out={pix[7:0], n[15:0]}.
REQ-019 HBLANK:
- Lasts H_BLANK cycles; de_out=0 and data_out=0.
- h_sync_out=1 on its first cycle only.
- Exit to the next LINE; after LINE V_LINES, exit to VBLANK.
REQ-020 VBLANK:
- Lasts V_BLANK cycles; v_sync_out=1 on its first cycle only.
- frame_cnt_out increments on that same cycle.
- On its last cycle: go to HEAD if enable_in=1, else go to IDLE.
REQ-021 enable_in deasserted mid-frame: the current frame completes unchanged; only the VBLANK exit test samples enable_in.
REQ-022 Line counter is 16 bits, resets to 1 at HEAD entry, and increments at each HBLANK exit; pixel counter resets at each line start.
REQ-023 There is no DE gap inside a line; consecutive lines are separated by exactly H_BLANK low cycles.

Reset
REQ-024 rst_n low forces IDLE asynchronously, regardless of state.
REQ-025 Reset values: de_out=0, de_first_offset_line_out=0, h_sync_out=0, v_sync_out=0, data_out=0, frame_cnt_out=0, pending-error flag=0.
REQ-026 Reset released mid-frame: restart from IDLE; no partial frame resumes.

Configuration
REQ-027 Macro TPG_ERROR_INJECT_EN defined:
- inject_error_in sets a pending flag; a pulse arriving during a frame applies to the following frame.
- The next frame's LINE 1 first pixel has data_out[0] inverted.
- The flag clears at that frame's VBLANK.
- Multiple pulses before the corruption occurs produce one corruption.
REQ-028 Macro TPG_ERROR_INJECT_EN undefined: inject_error_in is ignored, the flag logic is absent, and output is identical to a run with no pulse.

Verification
REQ-029 H_ACTIVE=4, H_BLANK=2, V_LINES=2, V_BLANK=4, enable held high:
- Header data is 800000, 800001, 800002, 800003.
- LINE1 data is 000001, 010001, 020001, 030001.
- h_sync_out pulses 3 times per frame; v_sync_out pulses once.
- Frame period is 3*(4+2)+4=22 cycles.
REQ-030 Connected to the downstream data verifier for 10 frames: total frames = 10, error frames = 0, error never asserted.
REQ-031 TPG_ERROR_INJECT_EN defined, inject_error_in pulsed during frame 2:
- Frame 3 LINE1 first pixel = 000000.
- Verifier error frames = 1; frame_cnt_out continues normally.
REQ-032 enable_in dropped during LINE 1 of frame 1: the frame completes with all pulses; then outputs stay low in IDLE; frame_cnt_out=1.
REQ-033 rst_n asserted in the middle of HBLANK: all outputs are 0 immediately, without waiting for a clock edge; after release plus enable, the first frame starts with header 800000 and frame_cnt_out=0.
REQ-034 frame_cnt_out forced to FFFFFFFF: the next VBLANK produces 00000000.

Source files
------------

// File: rtl/test_pattern_gen_if.sv
// Video-style stream between the pattern generator (master) and a sink (slave).
// The sink drives the enable/inject controls; the generator drives the pixel stream.
interface test_pattern_gen_if;
  logic        enable;
  logic        inject_error;
  logic        de;
  logic        de_first_offset_line;
  logic        h_sync;
  logic        v_sync;
  logic [23:0] data;
  logic [31:0] frame_cnt;

  modport master (
    input  enable, inject_error,
    output de, de_first_offset_line, h_sync, v_sync, data, frame_cnt
  );

  modport slave (
    output enable, inject_error,
    input  de, de_first_offset_line, h_sync, v_sync, data, frame_cnt
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Frame-based test pattern generator: header line, V_LINES data lines, blanking.
// Optional error injection is built only when TPG_ERROR_INJECT_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for enable, all outputs low
// S_HEAD   | header line active pixels
// S_LINE   | data line n active pixels
// S_HBLANK | horizontal blank after every line (header included)
// S_VBLANK | vertical blank after the last data line
module test_pattern_gen #(
  parameter int H_ACTIVE = 64,
  parameter int H_BLANK  = 16,
  parameter int V_LINES  = 32,
  parameter int V_BLANK  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  test_pattern_gen_if.master tpg
);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_LINE, S_HBLANK, S_VBLANK} state_t;

  localparam logic [31:0] HA_M1     = 32'(H_ACTIVE - 1);
  localparam logic [31:0] HB_M1     = 32'(H_BLANK - 1);
  localparam logic [31:0] VB_M1     = 32'(V_BLANK - 1);
  localparam logic [15:0] LAST_LINE = 16'(V_LINES);

  state_t      state_q, state_nxt;
  logic [31:0] timer_q, timer_nxt;
  logic [11:0] pix_q, pix_nxt;
  logic [15:0] line_q, line_nxt;
  logic        hdr_q, hdr_nxt;
  logic [31:0] frame_q, frame_nxt;

  logic        de_q, dfl_q, hs_q, vs_q;
  logic [23:0] data_q;
  logic        de_nxt, dfl_nxt, hs_nxt, vs_nxt;
  logic [23:0] data_nxt;
  logic        head_start;
  logic        corrupt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pix_q   <= '0;
      line_q  <= 16'd1;
      hdr_q   <= 1'b0;
      frame_q <= '0;
      de_q    <= 1'b0;
      dfl_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      pix_q   <= pix_nxt;
      line_q  <= line_nxt;
      hdr_q   <= hdr_nxt;
      frame_q <= frame_nxt;
      de_q    <= de_nxt;
      dfl_q   <= dfl_nxt;
      hs_q    <= hs_nxt;
      vs_q    <= vs_nxt;
      data_q  <= data_nxt;
    end
  end

  // Next-state and counters; the header's own HBLANK does not advance the line number.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    pix_nxt   = pix_q;
    line_nxt  = line_q;
    hdr_nxt   = hdr_q;
    case (state_q)
      S_IDLE: begin
        if (tpg.enable) begin
          state_nxt = S_HEAD;
          timer_nxt = HA_M1;
          pix_nxt   = '0;
          line_nxt  = 16'd1;
          hdr_nxt   = 1'b1;
        end
      end
      S_HEAD, S_LINE: begin
        if (timer_q == '0) begin
          state_nxt = S_HBLANK;
          timer_nxt = HB_M1;
        end else begin
          timer_nxt = timer_q - 32'd1;
          pix_nxt   = pix_q + 12'd1;
        end
      end
      S_HBLANK: begin
        if (timer_q == '0) begin
          timer_nxt = HA_M1;
          pix_nxt   = '0;
          if (hdr_q) begin
            state_nxt = S_LINE;
            hdr_nxt   = 1'b0;
          end else if (line_q == LAST_LINE) begin
            state_nxt = S_VBLANK;
            timer_nxt = VB_M1;
          end else begin
            state_nxt = S_LINE;
            line_nxt  = line_q + 16'd1;
          end
        end else begin
          timer_nxt = timer_q - 32'd1;
        end
      end
      S_VBLANK: begin
        if (timer_q == '0) begin
          if (tpg.enable) begin
            state_nxt = S_HEAD;
            timer_nxt = HA_M1;
            pix_nxt   = '0;
            line_nxt  = 16'd1;
            hdr_nxt   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer_q - 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    de_nxt    = (state_nxt == S_HEAD) || (state_nxt == S_LINE);
    dfl_nxt   = (state_nxt == S_HEAD);
    hs_nxt    = (state_nxt == S_HBLANK) && (state_q != S_HBLANK);
    vs_nxt    = (state_nxt == S_VBLANK) && (state_q != S_VBLANK);
    frame_nxt = vs_nxt ? frame_q + 32'd1 : frame_q;
    data_nxt  = '0;
    case (state_nxt)
      S_HEAD:  data_nxt = {16'h8000, pix_nxt[7:0]};
      S_LINE:  data_nxt = {pix_nxt[7:0], line_nxt} ^ {23'd0, corrupt};
      default: data_nxt = '0;
    endcase
  end

  assign head_start = (state_nxt == S_HEAD) && (state_q != S_HEAD);

`ifdef TPG_ERROR_INJECT_EN
  // pend collects requests for the next frame; arm marks the frame being corrupted.
  logic pend_q, arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      if (head_start) begin
        pend_q <= tpg.inject_error;
        arm_q  <= pend_q;
      end else begin
        if (tpg.inject_error) pend_q <= 1'b1;
        if (vs_nxt)           arm_q  <= 1'b0;
      end
    end
  end

  assign corrupt = arm_q && (state_nxt == S_LINE) && (line_nxt == 16'd1) && (pix_nxt == '0);
`else
  logic unused_inject;
  assign unused_inject = tpg.inject_error ^ head_start;
  assign corrupt       = 1'b0;
`endif

  assign tpg.de                   = de_q;
  assign tpg.de_first_offset_line = dfl_q;
  assign tpg.h_sync               = hs_q;
  assign tpg.v_sync               = vs_q;
  assign tpg.data                 = data_q;
  assign tpg.frame_cnt            = frame_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen with a 4/2/2/4 geometry (22-cycle frames).
module tb_test_pattern_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   err_frames = 0;
  bit   frame_bad;

`ifdef TPG_ERROR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  test_pattern_gen_if tpg();

  test_pattern_gen #(
    .H_ACTIVE(4),
    .H_BLANK (2),
    .V_LINES (2),
    .V_BLANK (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tpg  (tpg)
  );

  always #5 clk = ~clk;

  // {de, de_first_offset_line, h_sync, v_sync, data} for cycle k of an ideal frame
  function automatic logic [27:0] model(input int k);
    logic [27:0] r;
    r = '0;
    if (k < 4)                        r = {4'b1100, 16'h8000, 8'(k)};
    else if (k >= 6 && k < 10)        r = {4'b1000, 8'(k - 6), 16'd1};
    else if (k >= 12 && k < 16)       r = {4'b1000, 8'(k - 12), 16'd2};
    else if (k == 4 || k == 10 || k == 16) r = {4'b0010, 24'd0};
    else if (k == 18)                 r = {4'b0001, 24'd0};
    return r;
  endfunction

  function automatic logic [27:0] observed();
    return {tpg.de, tpg.de_first_offset_line, tpg.h_sync, tpg.v_sync, tpg.data};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame, starting at the edge that enters HEAD; also acts as the data verifier.
  task automatic run_frame(input logic [31:0] base, input bit corrupt,
                           input bit pulse, input int drop_k);
    logic [27:0] obs, exp, ideal;
    frame_bad = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      obs   = observed();
      ideal = model(k);
      exp   = ideal;
      if (corrupt && k == 6) exp[0] = ~exp[0];
      check($sformatf("out k=%0d", k), {4'd0, obs}, {4'd0, exp});
      check($sformatf("frame_cnt k=%0d", k), tpg.frame_cnt, (k >= 18) ? base + 32'd1 : base);
      if (obs !== ideal) frame_bad = 1'b1;
      tpg.inject_error = pulse && (k == 3 || k == 10);
      if (k == drop_k) tpg.enable = 1'b0;
    end
    if (frame_bad) err_frames++;
  endtask

  initial begin
    tpg.enable       = 1'b0;
    tpg.inject_error = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {4'd0, observed()}, 32'd0);
    check("reset_cnt", tpg.frame_cnt, 32'd0);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_out", {4'd0, observed()}, 32'd0);
    end

    // Ten back-to-back frames; inject pulses (two) during the second frame.
    tpg.enable = 1'b1;
    for (int f = 0; f < 10; f++)
      run_frame(32'(f), INJ && (f == 2), f == 1, -1);
    check("frames_total", tpg.frame_cnt, 32'd10);
    check("error_frames", 32'(err_frames), INJ ? 32'd1 : 32'd0);

    // Reset during the header's HBLANK of the eleventh frame.
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_hsync", {31'd0, tpg.h_sync}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {4'd0, observed()}, 32'd0);
    check("async_rst_cnt", tpg.frame_cnt, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Fresh frame after reset; enable dropped during LINE 1.
    run_frame(32'd0, 1'b0, 1'b0, 7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_after_drop_out", {4'd0, observed()}, 32'd0);
      check("idle_after_drop_cnt", tpg.frame_cnt, 32'd1);
    end

    // Frame counter wrap.
    force dut.frame_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_q;
    check("forced_cnt", tpg.frame_cnt, 32'hFFFF_FFFF);
    tpg.enable = 1'b1;
    run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 21);
    @(posedge clk); #1;
    check("wrap_idle_out", {4'd0, observed()}, 32'd0);
    check("wrap_idle_cnt", tpg.frame_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
